// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 digest output path.
package sha256_pkg;

    localparam int DIGEST_BYTES = 32;
    localparam int DIGEST_W     = DIGEST_BYTES * 8;

    // Beats per digest: one per byte in raw mode, one per nibble in hex mode.
    localparam int RAW_BEATS = DIGEST_BYTES;
    localparam int HEX_BEATS = DIGEST_BYTES * 2;

    // ASCII bases: '0' for digits, 'a' for letters (a-f use base minus 10).
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_BASE = 8'h61;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } stream_state_e;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational nibble to lowercase ASCII hex character encoder.
module hex_nibble_to_ascii
    import sha256_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    // Digits map onto '0'..'9', values ten and up onto 'a'..'f'.
    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_DIGIT_BASE + {4'b0000, nibble_i};
        end else begin
            ascii_o = (ASCII_ALPHA_BASE - 8'd10) + {4'b0000, nibble_i};
        end
    end

endmodule

// File: rtl/sha256_digest_streamer.sv
// Captures a SHA-256 digest on the rising edge of digest_valid and streams it
// MSB first over an 8-bit valid/ready port, as raw bytes or lowercase hex.
//
// Handshake: out_valid, out_data and out_last come only from registers. A beat
// transfers on a rising edge where out_valid and out_ready are both high; while
// out_valid is high and out_ready low, every output and internal state holds.
module sha256_digest_streamer
    import sha256_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [DIGEST_W-1:0] digest_in,
    input  logic                digest_valid,
    input  logic                hex_mode,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                overrun
);

    stream_state_e       state_q, state_d;
    logic [DIGEST_W-1:0] sreg_q, sreg_d;
    logic                mode_q, mode_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                dv_prev_q;
    logic                overrun_q, overrun_d;

    logic       capture;
    logic       send;
    logic       last_beat;
    logic       handshake;
    logic [5:0] final_cnt;
    logic [7:0] hex_char;

    assign capture   = digest_valid & ~dv_prev_q;
    assign send      = (state_q == ST_SEND);
    assign final_cnt = mode_q ? 6'(HEX_BEATS - 1) : 6'(RAW_BEATS - 1);
    assign last_beat = send && (cnt_q == final_cnt);
    assign handshake = send && out_ready;

    // The top nibble of the shift register is always the next hex character;
    // the nibble phase falls out of shifting by four per beat.
    hex_nibble_to_ascii u_hex (
        .nibble_i (sreg_q[DIGEST_W-1 -: 4]),
        .ascii_o  (hex_char)
    );

    assign out_data  = mode_q ? hex_char : sreg_q[DIGEST_W-1 -: 8];
    assign out_valid = send;
    assign out_last  = last_beat;
    assign busy      = send;
    assign overrun   = overrun_q;

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            dv_prev_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            dv_prev_q <= digest_valid;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: capture in IDLE, shift out on handshakes in SEND, flag
    // any capture event that arrives while a stream is still in flight.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    sreg_d  = digest_in;
                    mode_d  = hex_mode;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (capture) begin
                    overrun_d = 1'b1;
                end
                if (handshake) begin
                    if (mode_q) begin
                        sreg_d = {sreg_q[DIGEST_W-5:0], 4'h0};
                    end else begin
                        sreg_d = {sreg_q[DIGEST_W-9:0], 8'h00};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sha256_digest_streamer.sv
// Self-checking bench for sha256_digest_streamer: a queue of expected beats
// built from the digest, compared against the DUT on every falling edge.
module tb_sha256_digest_streamer;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIGEST =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    typedef logic [8:0] beat_arr_t [64];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] digest_in = '0;
    logic         digest_valid = 1'b0;
    logic         hex_mode = 1'b0;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic         busy;
    logic         overrun;

    sha256_digest_streamer dut (
        .clk          (clk),
        .rst          (rst),
        .digest_in    (digest_in),
        .digest_valid (digest_valid),
        .hex_mode     (hex_mode),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Clock and counters.
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    logic [8:0] exp_q[$];
    logic       exp_ovr = 1'b0;
    logic       dv_prev_m = 1'b0;
    int         rx_cnt = 0;
    int         rx_last_cnt = 0;
    int         stream_id = 0;
    logic [7:0] rx_log [64];
    int         ready_mode = 0;

    logic       m_cap, m_busy, m_hs;
    logic [8:0] m_item;
    beat_arr_t  m_beats;

    function automatic logic [7:0] to_hex(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h61 + ({4'h0, n} - 8'd10);
    endfunction

    // Expected beats {last, byte}: bytes MSB first, or two hex chars per byte.
    function automatic beat_arr_t gen(input logic [255:0] d, input logic hex);
        beat_arr_t a;
        logic [7:0] b;
        for (int i = 0; i < 64; i++) a[i] = '0;
        for (int i = 0; i < 32; i++) begin
            b = d[255 - 8*i -: 8];
            if (!hex) begin
                a[i] = {(i == 31), b};
            end else begin
                a[2*i]     = {1'b0, to_hex(b[7:4])};
                a[2*i + 1] = {(i == 31), to_hex(b[3:0])};
            end
        end
        return a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare outputs, then advance the model by the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_busy", {63'd0, busy}, 64'd0);
            check("rst_overrun", {63'd0, overrun}, 64'd0);
            check("rst_out_last", {63'd0, out_last}, 64'd0);
            check("rst_out_data", {56'd0, out_data}, 64'd0);
            exp_q.delete();
            exp_ovr   = 1'b0;
            dv_prev_m = 1'b0;
        end else begin
            m_busy = (exp_q.size() != 0);
            check("out_valid", {63'd0, out_valid}, {63'd0, m_busy});
            check("busy", {63'd0, busy}, {63'd0, m_busy});
            check("overrun", {63'd0, overrun}, {63'd0, exp_ovr});
            if (m_busy) begin
                check("out_data", {56'd0, out_data}, {56'd0, exp_q[0][7:0]});
                check("out_last", {63'd0, out_last}, {63'd0, exp_q[0][8]});
            end else begin
                check("idle_out_last", {63'd0, out_last}, 64'd0);
            end
            m_cap = digest_valid && !dv_prev_m;
            m_hs  = m_busy && out_ready;
            if (m_cap) begin
                if (m_busy) begin
                    exp_ovr = 1'b1;
                end else begin
                    m_beats = gen(digest_in, hex_mode);
                    for (int i = 0; i < (hex_mode ? 64 : 32); i++) exp_q.push_back(m_beats[i]);
                    rx_cnt = 0;
                    stream_id++;
                end
            end
            if (m_hs) begin
                m_item = exp_q.pop_front();
                rx_log[rx_cnt[5:0]] = out_data;
                rx_cnt++;
                if (m_item[8]) rx_last_cnt++;
            end
            dv_prev_m = digest_valid;
        end
    end

    // Sink: always ready, or random with long stalls on beats 0, 31 and 63.
    int          stall_left = 0;
    int          seen_id = 0;
    logic [63:0] stalled = '0;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            out_ready = 1'b1;
        end else begin
            if (stream_id != seen_id) begin
                stalled = '0;
                seen_id = stream_id;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if ((rx_cnt == 0 || rx_cnt == 31 || rx_cnt == 63) &&
                         !stalled[rx_cnt[5:0]] && exp_q.size() != 0) begin
                stalled[rx_cnt[5:0]] = 1'b1;
                stall_left = 11;
                out_ready = 1'b0;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Driver tasks.
    task automatic pulse(input logic [255:0] d, input logic hex);
        @(posedge clk); #1;
        digest_in    = d;
        hex_mode     = hex;
        digest_valid = 1'b1;
        @(posedge clk); #1;
        digest_valid = 1'b0;
        digest_in    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        hex_mode     = ~hex;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("stream_timeout", {63'd0, (exp_q.size() != 0)}, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_rx(input int k);
        int n = 0;
        while (rx_cnt < k && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("beat_timeout", {63'd0, (rx_cnt < k)}, 64'd0);
    endtask

    function automatic logic [255:0] rand_digest();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    beat_arr_t    pin;
    int           streams0;
    logic [255:0] d_a, d_b;

    initial begin
        // Model pins against hand-computed beats.
        pin = gen(ABC_DIGEST, 1'b0);
        check("pin_raw_first", {55'd0, pin[0]}, 64'h0BA);
        check("pin_raw_30", {55'd0, pin[30]}, 64'h015);
        check("pin_raw_last", {55'd0, pin[31]}, 64'h1AD);
        pin = gen(EMPTY_DIGEST, 1'b1);
        check("pin_hex_0", {55'd0, pin[0]}, 64'h065);
        check("pin_hex_1", {55'd0, pin[1]}, 64'h033);
        check("pin_hex_2", {55'd0, pin[2]}, 64'h062);
        check("pin_hex_63", {55'd0, pin[63]}, 64'h135);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Raw "abc" digest, sink always ready.
        streams0 = rx_last_cnt;
        pulse(ABC_DIGEST, 1'b0);
        wait_idle();
        check("abc_first", {56'd0, rx_log[0]}, 64'hBA);
        check("abc_last", {56'd0, rx_log[31]}, 64'hAD);
        check("abc_streams", 64'(rx_last_cnt - streams0), 64'd1);

        // Hex empty-string digest.
        pulse(EMPTY_DIGEST, 1'b1);
        wait_idle();
        check("empty_0", {56'd0, rx_log[0]}, 64'h65);
        check("empty_1", {56'd0, rx_log[1]}, 64'h33);
        check("empty_63", {56'd0, rx_log[63]}, 64'h35);

        // Random backpressure, hex then raw.
        ready_mode = 1;
        pulse(rand_digest(), 1'b1);
        wait_idle();
        pulse(rand_digest(), 1'b0);
        wait_idle();
        pulse(EMPTY_DIGEST, 1'b1);
        wait_idle();
        check("bp_empty_0", {56'd0, rx_log[0]}, 64'h65);
        check("bp_empty_63", {56'd0, rx_log[63]}, 64'h35);
        ready_mode = 0;
        @(posedge clk); #1;

        // Level-held digest_valid, then one-cycle drop and re-arm.
        streams0 = rx_last_cnt;
        digest_in    = rand_digest();
        hex_mode     = 1'b0;
        digest_valid = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("level_streams", 64'(rx_last_cnt - streams0), 64'd1);
        check("level_overrun", {63'd0, overrun}, 64'd0);
        digest_valid = 1'b0;
        @(posedge clk); #1;
        digest_in    = rand_digest();
        digest_valid = 1'b1;
        @(posedge clk); #1;
        check("rearm_valid", {63'd0, out_valid}, 64'd1);
        digest_valid = 1'b0;
        wait_idle();
        check("rearm_streams", 64'(rx_last_cnt - streams0), 64'd2);

        // Overrun: new rising edge at beat 10 of a raw stream.
        streams0 = rx_last_cnt;
        d_a = rand_digest();
        pulse(d_a, 1'b0);
        wait_rx(10);
        digest_in    = ~d_a;
        hex_mode     = 1'b1;
        digest_valid = 1'b1;
        @(posedge clk); #1;
        check("overrun_set", {63'd0, overrun}, 64'd1);
        digest_valid = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        check("overrun_streams", 64'(rx_last_cnt - streams0), 64'd1);
        check("overrun_first", {56'd0, rx_log[0]}, {56'd0, d_a[255:248]});
        check("overrun_last", {56'd0, rx_log[31]}, {56'd0, d_a[7:0]});

        // Asynchronous reset at beat 20, then a fresh stream.
        pulse(rand_digest(), 1'b0);
        wait_rx(20);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {63'd0, out_valid}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_overrun", {63'd0, overrun}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        d_b = rand_digest();
        pulse(d_b, 1'b0);
        wait_idle();
        check("restart_first", {56'd0, rx_log[0]}, {56'd0, d_b[255:248]});
        check("restart_last", {56'd0, rx_log[31]}, {56'd0, d_b[7:0]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
